// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE / ISSUE / WAIT)
//   DEF_*       : default parameter values for NUM_REQ, ADDR_W, DATA_W
//   id_width()  : width of a requester index, never less than one bit
package mem_port_arbiter_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DATA_W  = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: purely combinational.
//   i_req       : request vector, one bit per requester
//   i_rr_ptr    : index where the upward search begins
//   o_winner    : first set request at or above i_rr_ptr, wrapping modulo NUM_REQ
//   o_any_valid : high when any request bit is set
module rr_picker
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_rr_ptr,
   output logic [ID_W-1:0]    o_winner,
   output logic               o_any_valid
);

   int unsigned     w_idx;
   logic [ID_W-1:0] w_idx_s;

   always_comb begin
      o_winner    = '0;
      o_any_valid = 1'b0;
      w_idx       = 0;
      w_idx_s     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx   = (32'(i_rr_ptr) + k) % NUM_REQ;
         w_idx_s = ID_W'(w_idx);
         if (!o_any_valid && i_req[w_idx_s]) begin
            o_winner    = w_idx_s;
            o_any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by NUM_REQ pipeline stages.
// Round-robin grant in IDLE, one outstanding memory transaction at a time.
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_addr  : per-stage request and address
//   req_ready           : one-hot grant (IDLE only)
//   rsp_valid/rsp_data  : one-hot completion pulse and shared response data
//   mem_req_*           : request channel to memory
//   mem_rsp_*           : response channel from memory
//   busy                : high whenever the FSM is not in IDLE
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_W-1:0]              rsp_data,
   output logic                           mem_req_valid,
   output logic [ADDR_W-1:0]              mem_req_addr,
   input  logic                           mem_req_ready,
   input  logic                           mem_rsp_valid,
   input  logic [DATA_W-1:0]              mem_rsp_data,
   output logic                           busy
);

   localparam int unsigned ID_W = id_width(NUM_REQ);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [ID_W-1:0]   r_rr_ptr;

   logic [ID_W-1:0]   w_winner;
   logic              w_any_valid;
   logic              w_capture;
   logic              w_complete;
   logic [ID_W-1:0]   w_next_ptr;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_picker (
      .i_req       (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_winner    (w_winner),
      .o_any_valid (w_any_valid)
   );

   assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_id     <= '0;
         r_addr   <= '0;
         r_rr_ptr <= '0;
      end else begin
         if (w_capture) begin
            r_id   <= w_winner;
            r_addr <= req_addr[w_winner];
         end
         if (w_complete) begin
            r_rr_ptr <= w_next_ptr;
         end
      end
   end

   // req_ready is combinational from req_valid, so it is also gated by reset
   // to keep every output low while reset is held.
   always_comb begin
      w_next_state  = r_state;
      w_capture     = 1'b0;
      w_complete    = 1'b0;
      req_ready     = '0;
      rsp_valid     = '0;
      rsp_data      = '0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any_valid && reset) begin
               req_ready    = NUM_REQ'(1) << w_winner;
               w_capture    = 1'b1;
               w_next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = r_addr;
            if (mem_req_ready) begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_rsp_valid) begin
               rsp_valid    = NUM_REQ'(1) << r_id;
               rsp_data     = mem_rsp_data;
               w_complete   = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;

   logic                  clk;
   logic                  reset;
   logic [N-1:0]          req_valid;
   logic [N-1:0][AW-1:0]  req_addr;
   logic [N-1:0]          req_ready;
   logic [N-1:0]          rsp_valid;
   logic [DW-1:0]         rsp_data;
   logic                  mem_req_valid;
   logic [AW-1:0]         mem_req_addr;
   logic                  mem_req_ready;
   logic                  mem_rsp_valid;
   logic [DW-1:0]         mem_rsp_data;
   logic                  busy;

   int n_assert = 0;
   int n_fail   = 0;

   mem_port_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (AW),
      .DATA_W  (DW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_req_ready (mem_req_ready),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Reference round-robin rule: first set bit searching upward from ptr.
   function automatic int pick(input int ptr, input logic [N-1:0] rv);
      for (int k = 0; k < int'(N); k++) begin
         if (rv[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int id);
      logic [N-1:0] v;
      v = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   initial begin
      int            ptr;
      int            w;
      int            n;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] d;
      logic [N-1:0]  rv;
      logic [N-1:0]  er;

      reset         = 1'b0;
      req_valid     = 4'hF;
      req_addr      = '0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h1234;

      // Outputs held low during reset, even with live inputs.
      sample();
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_rsp_data", rsp_data, 64'h0);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
      chk("rst_mem_req_addr", 64'(mem_req_addr), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      tick();
      reset         = 1'b1;
      req_valid     = 4'b0100;
      req_addr[2]   = 32'h100;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;

      // Single request from stage 2.
      sample();
      chk("a_grant", 64'(req_ready), 64'h4);
      chk("a_busy0", 64'(busy), 64'h0);
      tick();
      req_valid = '0;
      sample();
      chk("a_mem_valid", 64'(mem_req_valid), 64'h1);
      chk("a_mem_addr", 64'(mem_req_addr), 64'h100);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hAA;
      sample();
      chk("a_rsp_valid", 64'(rsp_valid), 64'h4);
      chk("a_rsp_data", rsp_data, 64'hAA);
      tick();
      mem_rsp_valid = 1'b0;
      sample();
      chk("a_rsp_idle", 64'(rsp_valid), 64'h0);
      chk("a_rsp_data0", rsp_data, 64'h0);
      chk("a_busy_end", 64'(busy), 64'h0);

      // Reset from IDLE so the pointer restarts at 0.
      reset = 1'b0;
      tick();
      reset = 1'b1;

      // All requesters valid, zero-latency memory.
      for (int i = 0; i < int'(N); i++) req_addr[i] = 32'h1000 + 32'(i * 16);
      req_valid     = 4'hF;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      for (int c = 0; c < 13; c++) begin
         d = {$urandom, $urandom};
         mem_rsp_data = d;
         sample();
         er = (c % 3 == 0) ? onehot((c / 3) % N) : '0;
         chk($sformatf("b_ready_c%0d", c), 64'(req_ready), 64'(er));
         er = (c % 3 == 2) ? onehot((c / 3) % N) : '0;
         chk($sformatf("b_rsp_c%0d", c), 64'(rsp_valid), 64'(er));
         chk($sformatf("b_data_c%0d", c), rsp_data, (er != '0) ? d : 64'h0);
         chk($sformatf("b_memv_c%0d", c), 64'(mem_req_valid), (c % 3 == 1) ? 64'h1 : 64'h0);
         tick();
      end

      // Now in ISSUE for requester 0: memory stalls with stray responses.
      mem_req_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         mem_rsp_valid = c[0];
         req_valid     = 4'(c * 3);
         req_addr[2]   = 32'h7700 + 32'(c);
         sample();
         chk($sformatf("c_memv_%0d", c), 64'(mem_req_valid), 64'h1);
         chk($sformatf("c_addr_%0d", c), 64'(mem_req_addr), 64'h1000);
         chk($sformatf("c_ready_%0d", c), 64'(req_ready), 64'h0);
         chk($sformatf("c_rsp_%0d", c), 64'(rsp_valid), 64'h0);
         tick();
      end
      req_valid     = 4'hF;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      sample();
      chk("c_accept_rsp", 64'(rsp_valid), 64'h0);
      chk("c_accept_busy", 64'(busy), 64'h1);
      tick();
      mem_rsp_valid = 1'b0;
      sample();
      chk("d_wait_busy", 64'(busy), 64'h1);
      chk("d_wait_rsp", 64'(rsp_valid), 64'h0);

      // Reset pulse mid-cycle while in WAIT.
      reset         = 1'b0;
      mem_rsp_valid = 1'b1;
      #1;
      chk("d_rst_busy", 64'(busy), 64'h0);
      chk("d_rst_rsp", 64'(rsp_valid), 64'h0);
      chk("d_rst_ready", 64'(req_ready), 64'h0);
      req_valid = '0;
      tick();
      reset = 1'b1;
      sample();
      chk("d_late_rsp", 64'(rsp_valid), 64'h0);
      chk("d_late_busy", 64'(busy), 64'h0);
      tick();
      mem_rsp_valid = 1'b0;
      req_valid     = 4'b1010;
      req_addr[1]   = 32'h2222_0000;
      sample();
      chk("d_regrant", 64'(req_ready), 64'h2);
      tick();

      // Granted requester withdraws and changes its address.
      req_valid     = '0;
      req_addr[1]   = 32'hDEAD_BEEF;
      mem_req_ready = 1'b1;
      sample();
      chk("e_addr", 64'(mem_req_addr), 64'h2222_0000);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h55;
      sample();
      chk("e_rsp", 64'(rsp_valid), 64'h2);
      chk("e_data", rsp_data, 64'h55);
      tick();
      mem_rsp_valid = 1'b0;
      ptr = 2;

      // Randomized transactions against the transaction-level model.
      for (int t = 0; t < 30; t++) begin
         n = $urandom_range(0, 2);
         for (int i = 0; i < n; i++) begin
            req_valid     = '0;
            mem_rsp_valid = 1'($urandom);
            mem_req_ready = 1'($urandom);
            sample();
            chk("r_idle_ready", 64'(req_ready), 64'h0);
            chk("r_idle_rsp", 64'(rsp_valid), 64'h0);
            chk("r_idle_busy", 64'(busy), 64'h0);
            tick();
         end
         rv = 4'($urandom_range(1, 15));
         req_valid = rv;
         for (int i = 0; i < int'(N); i++) req_addr[i] = $urandom;
         mem_rsp_valid = 1'($urandom);
         w = pick(ptr, rv);
         exp_addr = req_addr[w];
         sample();
         chk($sformatf("r_grant_t%0d", t), 64'(req_ready), 64'(onehot(w)));
         tick();
         n = $urandom_range(0, 3);
         for (int i = 0; i <= n; i++) begin
            mem_req_ready = (i == n);
            mem_rsp_valid = 1'($urandom);
            req_valid     = 4'($urandom);
            for (int j = 0; j < int'(N); j++) req_addr[j] = $urandom;
            sample();
            chk($sformatf("r_memv_t%0d", t), 64'(mem_req_valid), 64'h1);
            chk($sformatf("r_addr_t%0d", t), 64'(mem_req_addr), 64'(exp_addr));
            chk("r_issue_ready", 64'(req_ready), 64'h0);
            chk("r_issue_rsp", 64'(rsp_valid), 64'h0);
            tick();
         end
         n = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) begin
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'($urandom);
            sample();
            chk("r_wait_memv", 64'(mem_req_valid), 64'h0);
            chk("r_wait_rsp", 64'(rsp_valid), 64'h0);
            chk("r_wait_busy", 64'(busy), 64'h1);
            tick();
         end
         d = {$urandom, $urandom};
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = d;
         sample();
         chk($sformatf("r_rsp_t%0d", t), 64'(rsp_valid), 64'(onehot(w)));
         chk($sformatf("r_data_t%0d", t), rsp_data, d);
         tick();
         mem_rsp_valid = 1'b0;
         ptr = (w + 1) % N;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of pipeline-stage requesters sharing one memory port.
REQ-002 Parameter ADDR_W, default 32: memory address width.
REQ-003 Parameter DATA_W, default 64: memory data width, matching the stage src_data bus.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-stage memory request pending.
REQ-007 req_addr  input  NUM_REQ x ADDR_W  per-stage request address.
REQ-008 req_ready  output  NUM_REQ  one-hot grant; request accepted this cycle.
REQ-009 rsp_valid  output  NUM_REQ  one-hot completion pulse to the stage `complete` input.
REQ-010 rsp_data  output  DATA_W  response data, shared by all stages.
REQ-011 mem_req_valid  output  1  request to memory.
REQ-012 mem_req_addr  output  ADDR_W  address to memory.
REQ-013 mem_req_ready  input  1  memory accepts request.
REQ-014 mem_rsp_valid  input  1  memory response valid.
REQ-015 mem_rsp_data  input  DATA_W  memory response data.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-018 In IDLE with any req_valid set, the winner SHALL be the first set bit searched upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-019 In IDLE, req_ready SHALL be asserted combinationally for the winner only; on that edge the FSM SHALL register the winner id and req_addr[id] and go to ISSUE.
REQ-020 req_ready SHALL be all-zero outside IDLE and when no req_valid is set.
REQ-021 In ISSUE, mem_req_valid SHALL be 1 and mem_req_addr SHALL equal the captured address; the FSM SHALL stay in ISSUE until mem_req_ready=1, then go to WAIT.
REQ-022 In WAIT, when mem_rsp_valid=1: rsp_valid[id] SHALL be 1 in that cycle, rsp_data SHALL equal mem_rsp_data, the FSM SHALL go to IDLE, and rr_ptr SHALL become (id+1) mod NUM_REQ.
REQ-023 mem_rsp_valid SHALL be ignored outside WAIT; rsp_valid SHALL be all-zero outside the REQ-022 cycle.
REQ-024 Only one memory transaction SHALL be outstanding; the minimum grant-to-grant spacing SHALL be 3 cycles.
REQ-025 Address, winner id and memory data SHALL pass unmodified, with no width conversion.
REQ-026 Deasserting req_valid after grant SHALL NOT cancel the captured transaction.
REQ-027 Changing req_valid or req_addr of non-granted stages SHALL NOT affect an in-flight transaction.
REQ-028 rsp_data SHALL be 0 whenever rsp_valid is all-zero.

Reset
REQ-029 Asserting reset (low) SHALL immediately force: state=IDLE, rr_ptr=0, captured id=0, captured address=0.
REQ-030 While reset is asserted, all outputs SHALL be 0.
REQ-031 Reset during ISSUE or WAIT SHALL abandon the transaction; its late mem_rsp_valid SHALL be ignored per REQ-023.
REQ-032 The first arbitration after reset release SHALL search from requester 0.

Structure
REQ-033 The arb_state_t enum and default NUM_REQ/ADDR_W/DATA_W constants SHALL live in the shared types package.
REQ-034 Round-robin selection SHALL be a sub-module, rr_picker: inputs req vector and rr_ptr; outputs winner id and any-valid flag; purely combinational.
REQ-035 The FSM, capture registers and rr_ptr SHALL reside in mem_port_arbiter.

Verification
REQ-036 Stimulus: only req 2 valid, addr 0x100; mem_req_ready=1; response 0xAA one cycle later.
  Required: req_ready=0b0100 in cycle 0; mem_req_valid with addr 0x100 in cycle 1; rsp_valid=0b0100 and rsp_data=0xAA in cycle 2.
REQ-037 Stimulus: all four reqs held valid.
  Required: grant order 0,1,2,3,0; each grant exactly 3 cycles apart with zero-latency memory.
REQ-038 Stimulus: mem_req_ready held 0 for 5 cycles.
  Required: mem_req_valid and mem_req_addr stable for all 5 cycles; no req_ready asserted.
REQ-039 Stimulus: reset pulsed low in WAIT, then mem_rsp_valid=1 after release.
  Required: no rsp_valid; busy=0; next grant goes to lowest valid id starting at 0.
REQ-040 Stimulus: stray mem_rsp_valid in IDLE and in ISSUE.
  Required: rsp_valid stays 0 and the FSM state is unchanged.
REQ-041 Stimulus: granted requester drops req_valid and changes req_addr after grant.
  Required: the captured address is issued unchanged and the response is returned to that requester.
